buf_rx_fifo: RTL and testbench
==============================

Name: buf_rx_fifo

Overview:
Clocked, synthesizable consumer for the buffer stage's four-phase output handshake (BtoR_REQ / RtoB_ACK / DO).
- Synchronizes the incoming request and captures each data word into a small FIFO.
- Drains the FIFO through a valid/ready port to downstream logic.
- Replaces the behavioural delay-based receiver in the handshake testbench chain, and applies back-pressure by withholding ack when full.

Parameters:
DATA_W, 32, width of data word
DEPTH, 4, FIFO entries; power of 2, >= 2
SYNC_STAGES, 2, flops on req_in synchronizer; >= 2

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_in  input  1  four-phase request from buffer stage (BtoR_REQ); asynchronous to clk
data_in  input  DATA_W  data from buffer stage (DO); stable while req_in=1
ack_out  output  1  four-phase acknowledge (RtoB_ACK); registered
out_valid  output  1  FIFO non-empty
out_ready  input  1  downstream accepts head word
out_data  output  DATA_W  FIFO head word
level  output  $clog2(DEPTH)+1  current FIFO occupancy
seq_err  output  1  sequence error flag, sticky (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - Synchronizer flops cleared.
  - FSM=IDLE, ack_out=0.
  - FIFO pointers and count cleared: level=0, out_valid=0.
  - seq_err=0.
  - out_data is don't-care while empty.
- Synchronizer: req_s = req_in delayed through SYNC_STAGES flops. Only req_s is used by the FSM.
- FSM states: IDLE, HOLD, ACK.
  - IDLE: req_s=1 and count<DEPTH -> push data_in, ack_out<=1, go ACK. req_s=1 and count==DEPTH -> go HOLD, ack_out stays 0. req_s=0 -> stay.
  - HOLD: count<DEPTH -> push data_in, ack_out<=1, go ACK. req_s=0 (request withdrawn, protocol violation) -> IDLE, no push.
  - ACK: req_s=0 -> ack_out<=0, go IDLE. Otherwise hold.
- Latency: ack_out rises on the (SYNC_STAGES+1)th rising edge after req_in rises, provided the FIFO is not full. ack_out falls on the (SYNC_STAGES+1)th edge after req_in falls.
- Exactly one push per request. A request held high never causes a second push.
- Data is sampled on the push edge only; data_in is not registered elsewhere.
- FIFO:
  - Pop occurs when out_valid && out_ready at a rising edge. out_data always shows the head entry (first-word fall-through).
  - Push eligibility uses count before the edge. A pop in the same cycle does NOT enable a push when count==DEPTH.
  - Simultaneous push+pop with 0<count<DEPTH: level unchanged, order preserved.
  - Pop while empty: ignored.
  - Read/write pointers wrap modulo DEPTH.
  - level = count, range 0..DEPTH.
- Reset mid-handshake:
  - All state clears immediately; ack_out drops asynchronously.
  - If req_in is still high after reset release, it is treated as a new request and the word is captured again. The upstream stage is reset together with this block.

Optional Feature:
BUF_RX_SEQ_CHECK_EN
- Defined:
  - Block keeps a DATA_W expected register and a first-word flag.
  - The first push after reset loads expected = data_in+1.
  - Each later push compares data_in to expected (mod 2^DATA_W). On mismatch, seq_err<=1 on that push edge, sticky until reset.
  - expected is then reloaded with data_in+1.
- Not defined: seq_err tied to 0, and no comparator or expected-register logic is present.

Test Plan:
1. SYNC_STAGES=2; reset, then req_in=1 with data_in=0x5 -> ack_out=1 on 3rd edge, out_valid=1, out_data=0x5, level=1. Drop req_in -> ack_out=0 on 3rd edge.
2. Drive sequence 0..99 with out_ready=1 throughout -> 100 words emitted in order 0..99, each handshake completes, level never exceeds 1, seq_err=0.
3. out_ready=0, DEPTH=4, send 5 words -> 4 accepted (level=4). Fifth request sits in HOLD with ack_out=0. One-cycle out_ready pulse -> level 3, then push on next edge, ack_out=1, level=4, out_data=first word's successor.
4. level=2, push and pop on same edge -> level stays 2, out_data advances to the second word.
5. Assert rst_n=0 while in ACK (ack_out=1, level=3) -> ack_out, out_valid and level all 0 without waiting for a clock edge.
6. With BUF_RX_SEQ_CHECK_EN: send 0,1,3,4 -> seq_err rises on the edge pushing 3 and stays 1 through the push of 4. Without the macro: same stimulus -> seq_err=0.

Source files
------------

// File: rtl/buf_rx_fifo.sv
// rtl/buf_rx_fifo.sv - four-phase handshake receiver feeding a first-word-fall-through FIFO
//
// Purpose:
//   Consumes the buffer stage's four-phase output handshake (BtoR_REQ / RtoB_ACK / DO).
//   req_in is synchronized, each request pushes exactly one data word into a small FIFO,
//   and the FIFO drains through a valid/ready port. When the FIFO is full the request is
//   parked (HOLD) and ack is withheld, which back-pressures the upstream stage.
//
// Optional feature macro: BUF_RX_SEQ_CHECK_EN
//   Defined  : each push after the first is checked against previous word + 1;
//              a mismatch sets the sticky seq_err flag.
//   Undefined: seq_err is tied to 0.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   req_in    in   four-phase request (asynchronous to clk)
//   data_in   in   DATA_W data word, stable while req_in=1
//   ack_out   out  four-phase acknowledge, registered
//   out_valid out  FIFO non-empty
//   out_ready in   downstream accepts head word
//   out_data  out  DATA_W FIFO head word (fall-through)
//   level     out  FIFO occupancy, 0..DEPTH
//   seq_err   out  sticky sequence error flag

module buf_rx_fifo #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_in,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     ack_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     seq_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } stateT;

  // ---------------------------------------------------------------------------
  // Request synchronizer
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] syncQ;
  logic                   reqS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncQ <= '0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], req_in};
    end
  end

  assign reqS = syncQ[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FIFO storage and occupancy
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr;
  logic [AW-1:0]     rdPtr;
  logic [CW-1:0]     count;
  logic              full;
  logic              doPush;
  logic              doPop;

  // Full is judged on the pre-edge count, so a pop in the same cycle cannot
  // open room for a push; that push waits one more edge.
  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign doPop     = out_valid && out_ready;
  assign out_data  = mem[rdPtr];
  assign level     = count;

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  stateT state;
  stateT stateNext;
  logic  ackQ;
  logic  ackNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ackQ  <= 1'b0;
    end else begin
      state <= stateNext;
      ackQ  <= ackNext;
    end
  end

  always_comb begin
    stateNext = state;
    ackNext   = ackQ;
    doPush    = 1'b0;
    unique case (state)
      IDLE: begin
        if (reqS) begin
          if (!full) begin
            doPush    = 1'b1;
            ackNext   = 1'b1;
            stateNext = ACK;
          end else begin
            stateNext = HOLD;
          end
        end
      end
      HOLD: begin
        // A withdrawn request wins over a freed slot: nothing is captured
        // for a request the upstream no longer presents.
        if (!reqS) begin
          stateNext = IDLE;
        end else if (!full) begin
          doPush    = 1'b1;
          ackNext   = 1'b1;
          stateNext = ACK;
        end
      end
      ACK: begin
        // Stay here while req_s is high so a held request pushes only once.
        if (!reqS) begin
          ackNext   = 1'b0;
          stateNext = IDLE;
        end
      end
      default: begin
        ackNext   = 1'b0;
        stateNext = IDLE;
      end
    endcase
  end

  assign ack_out = ackQ;

  // ---------------------------------------------------------------------------
  // Pointer and count update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      unique case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; out_data is meaningless while empty.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional incrementing-sequence checker
  // ---------------------------------------------------------------------------
`ifdef BUF_RX_SEQ_CHECK_EN
  logic [DATA_W-1:0] expectQ;
  logic              haveFirst;
  logic              seqErrQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expectQ   <= '0;
      haveFirst <= 1'b0;
      seqErrQ   <= 1'b0;
    end else if (doPush) begin
      haveFirst <= 1'b1;
      expectQ   <= data_in + DATA_W'(1);
      if (haveFirst && (data_in != expectQ)) begin
        seqErrQ <= 1'b1;
      end
    end
  end

  assign seq_err = seqErrQ;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_buf_rx_fifo.sv
// tb/tb_buf_rx_fifo.sv - directed self-checking bench for buf_rx_fifo

module tb_buf_rx_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int SYNC   = 2;

`ifdef BUF_RX_SEQ_CHECK_EN
  localparam logic EXP_SEQ = 1'b1;
`else
  localparam logic EXP_SEQ = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              req_in;
  logic [DATA_W-1:0] data_in;
  logic              ack_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [$clog2(DEPTH):0] level;
  logic              seq_err;

  int nChecks = 0;
  int nFails  = 0;

  logic              collect = 1'b0;
  logic [DATA_W-1:0] popQ[$];
  int                maxLevel = 0;

  buf_rx_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .data_in  (data_in),
    .ack_out  (ack_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .level    (level),
    .seq_err  (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge, so negedge values are the
  // ones the next rising edge sees.
  always @(negedge clk) begin
    if (collect) begin
      if (out_valid && out_ready) popQ.push_back(out_data);
      if (int'(level) > maxLevel) maxLevel = int'(level);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n   = 1'b0;
    req_in  = 1'b0;
    data_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic waitAck(input string tag, input logic val);
    int n = 0;
    while (ack_out !== val && n < 20) begin
      tick();
      n++;
    end
    check(tag, ack_out, val);
  endtask

  task automatic reqUp(input logic [DATA_W-1:0] d);
    data_in = d;
    req_in  = 1'b1;
    waitAck("ack_rise", 1'b1);
  endtask

  task automatic reqDown();
    req_in = 1'b0;
    waitAck("ack_fall", 1'b0);
  endtask

  task automatic sendWord(input logic [DATA_W-1:0] d);
    reqUp(d);
    reqDown();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    out_ready = 1'b0;

    // Reset state
    doReset();
    check("rst_ack", ack_out, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_level", level, 0);
    check("rst_seqerr", seq_err, 1'b0);

    // 1: ack latency is SYNC_STAGES+1 edges in both directions
    data_in = 32'h5;
    req_in  = 1'b1;
    tick();
    tick();
    check("t1_ack_edge2", ack_out, 1'b0);
    tick();
    check("t1_ack_edge3", ack_out, 1'b1);
    check("t1_valid", out_valid, 1'b1);
    check("t1_data", out_data, 32'h5);
    check("t1_level", level, 1);
    req_in = 1'b0;
    tick();
    tick();
    check("t1_ackfall_edge2", ack_out, 1'b1);
    tick();
    check("t1_ackfall_edge3", ack_out, 1'b0);
    tick();
    tick();
    tick();
    tick();
    check("t1_single_push", level, 1);

    // 2: 100-word stream with continuous drain
    doReset();
    out_ready = 1'b1;
    popQ.delete();
    maxLevel = 0;
    collect  = 1'b1;
    for (int i = 0; i < 100; i++) sendWord(DATA_W'(i));
    tick();
    tick();
    collect = 1'b0;
    check("t2_count", popQ.size(), 100);
    bad = 0;
    for (int i = 0; i < popQ.size(); i++) if (popQ[i] !== DATA_W'(i)) bad++;
    check("t2_order_errs", bad, 0);
    check("t2_maxlevel", maxLevel, 1);
    check("t2_seqerr", seq_err, 1'b0);
    check("t2_empty", out_valid, 1'b0);

    // 3: full FIFO parks the fifth request until a slot frees
    doReset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sendWord(DATA_W'(32'h10 + i));
    check("t3_level_full", level, 4);
    data_in = 32'h14;
    req_in  = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("t3_hold_ack", ack_out, 1'b0);
    check("t3_hold_level", level, 4);
    check("t3_head", out_data, 32'h10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_pop_level", level, 3);
    check("t3_pop_ack", ack_out, 1'b0);
    check("t3_pop_head", out_data, 32'h11);
    tick();
    check("t3_push_ack", ack_out, 1'b1);
    check("t3_push_level", level, 4);
    check("t3_push_head", out_data, 32'h11);
    reqDown();

    // 4: simultaneous push and pop at level 2
    doReset();
    out_ready = 1'b0;
    sendWord(32'h20);
    sendWord(32'h21);
    check("t4_level2", level, 2);
    data_in = 32'h22;
    req_in  = 1'b1;
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_pp_ack", ack_out, 1'b1);
    check("t4_pp_level", level, 2);
    check("t4_pp_head", out_data, 32'h21);
    reqDown();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_drain_head", out_data, 32'h22);
    check("t4_drain_level", level, 1);

    // 5: asynchronous reset in ACK, then held request is re-captured
    doReset();
    out_ready = 1'b0;
    sendWord(32'h30);
    sendWord(32'h31);
    reqUp(32'h32);
    check("t5_pre_level", level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_ack", ack_out, 1'b0);
    check("t5_async_valid", out_valid, 1'b0);
    check("t5_async_level", level, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("t5_recap_edge2", ack_out, 1'b0);
    tick();
    check("t5_recap_ack", ack_out, 1'b1);
    check("t5_recap_level", level, 1);
    check("t5_recap_data", out_data, 32'h32);
    reqDown();

    // 6: sequence checker (expected result depends on build option)
    doReset();
    out_ready = 1'b1;
    sendWord(32'h0);
    sendWord(32'h1);
    check("t6_after1", seq_err, 1'b0);
    reqUp(32'h3);
    check("t6_push3", seq_err, EXP_SEQ);
    reqDown();
    reqUp(32'h4);
    check("t6_push4", seq_err, EXP_SEQ);
    reqDown();
    doReset();
    check("t6_reset_clear", seq_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
